// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad receive path.
// Key layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / E(*) 0 F(#) D, indexed by row*4 + col.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    // Entry 0 is the rightmost element: KEY_MAP[0] = 4'h1.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} kp_state_t;

    function automatic logic is_single(input logic [ROWS-1:0] r);
        return $countones(r) == 1;
    endfunction

    function automatic logic [1:0] row_index(input logic [ROWS-1:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < ROWS; i++)
            if (r[i]) idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/row_synchronizer.sv
// Synchronizes the raw row lines and delays the column index by the same depth,
// so each synchronized row sample is paired with the column that produced it.
module row_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] column_index,
    input  logic [3:0] row_in,
    output logic [1:0] col_s,
    output logic [3:0] row_s
);

    logic [SYNC_STAGES-1:0][3:0] row_q;
    logic [SYNC_STAGES-1:0][1:0] col_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q[0] <= row_in;
            col_q[0] <= column_index;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                row_q[i] <= row_q[i-1];
                col_q[i] <= col_q[i-1];
            end
        end
    end

    assign row_s = row_q[SYNC_STAGES-1];
    assign col_s = col_q[SYNC_STAGES-1];

endmodule

// File: rtl/keypad_row_reader.sv
// Keypad row reader: debounces one key over whole scan cycles and reports it once per press.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key stays held.
module keypad_row_reader
    import keypad_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int DEBOUNCE_SCANS     = 4,
    parameter int REPEAT_DELAY_SCANS = 50,
    parameter int REPEAT_RATE_SCANS  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] column_index,
    input  logic [3:0] row_in,
    output logic       key_valid,
    output logic [3:0] key_pos,
    output logic [3:0] key_value,
    output logic       key_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [1:0]       col_s, cand_col, cand_col_n;
    logic [3:0]       row_s;
    logic [1:0]       cand_row, cand_row_n, row_idx;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]       key_pos_n;
    logic             key_valid_n, single, cand_hit;
    kp_state_t        state, state_n;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY_SCANS + 1);
    logic [REP_W-1:0] rep_cnt, rep_n;
`endif

    row_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk          (clk),
        .rst          (rst),
        .column_index (column_index),
        .row_in       (row_in),
        .col_s        (col_s),
        .row_s        (row_s)
    );

    assign single   = is_single(row_s);
    assign row_idx  = row_index(row_s);
    assign cand_hit = (col_s == cand_col);
    assign cnt_inc  = (cnt == CNT_W'(DEBOUNCE_SCANS)) ? cnt : cnt + CNT_W'(1);
    assign key_held = (state == PRESSED) || (state == RELEASE);

    always_comb begin
        state_n     = state;
        cand_col_n  = cand_col;
        cand_row_n  = cand_row;
        cnt_n       = cnt;
        key_valid_n = 1'b0;
        key_pos_n   = key_pos;
`ifdef KEYPAD_REPEAT_EN
        rep_n       = rep_cnt;
`endif
        case (state)
            IDLE: if (single) begin
                cand_col_n = col_s;
                cand_row_n = row_idx;
                cnt_n      = CNT_W'(1);
                state_n    = DEBOUNCE;
            end
            DEBOUNCE: if (cand_hit) begin
                if (single && row_idx == cand_row) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                        state_n     = PRESSED;
                        cnt_n       = '0;
                        key_valid_n = 1'b1;
                        key_pos_n   = {cand_row, cand_col};
`ifdef KEYPAD_REPEAT_EN
                        rep_n       = '0;
`endif
                    end
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            PRESSED: if (cand_hit) begin
                if (!row_s[cand_row]) begin
                    state_n = RELEASE;
                    cnt_n   = CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
                    rep_n   = '0;
                end else begin
                    // Reloading with DELAY-RATE makes later repeats land every RATE visits.
                    rep_n = rep_cnt + REP_W'(1);
                    if (rep_n == REP_W'(REPEAT_DELAY_SCANS)) begin
                        key_valid_n = 1'b1;
                        rep_n       = REP_W'(REPEAT_DELAY_SCANS - REPEAT_RATE_SCANS);
                    end
`endif
                end
            end
            RELEASE: if (cand_hit) begin
                if (!row_s[cand_row]) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end else begin
                    state_n = PRESSED;
                    cnt_n   = '0;
`ifdef KEYPAD_REPEAT_EN
                    rep_n   = '0;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand_col  <= '0;
            cand_row  <= '0;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_pos   <= '0;
            key_value <= KEY_MAP[0];
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_n;
            cand_col  <= cand_col_n;
            cand_row  <= cand_row_n;
            cnt       <= cnt_n;
            key_valid <= key_valid_n;
            key_pos   <= key_pos_n;
            key_value <= KEY_MAP[key_pos_n];
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= rep_n;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_row_reader.sv
// Self-checking bench for keypad_row_reader: directed scenarios plus random presses,
// compared every cycle against a scan-level model. Honours KEYPAD_REPEAT_EN.
module tb_keypad_row_reader;

    localparam int SYNC = 2;
    localparam int DB   = 4;
`ifdef KEYPAD_REPEAT_EN
    localparam int DELAY = 50;
    localparam int RATE  = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] column_index;
    logic [3:0] row_in;
    logic       key_valid;
    logic [3:0] key_pos;
    logic [3:0] key_value;
    logic       key_held;

    keypad_row_reader dut (
        .clk          (clk),
        .rst          (rst),
        .column_index (column_index),
        .row_in       (row_in),
        .key_valid    (key_valid),
        .key_pos      (key_pos),
        .key_value    (key_value),
        .key_held     (key_held)
    );

    always #5 clk = ~clk;

    int key_map_ref [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    int n_assert = 0, n_fail = 0, pulses = 0;
    logic [15:0] keys;

    // Model: held flag plus one streak counter (toward press when idle, toward release when held).
    logic [1:0] hist_col [$];
    logic [3:0] hist_row [$];
    bit m_held, e_valid;
    int m_cand, m_streak, m_rep, e_pos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rows_of(input logic [15:0] k, input logic [1:0] c);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = k[i*4 + int'(c)];
        return r;
    endfunction

    task automatic model_reset();
        hist_col = {};
        hist_row = {};
        for (int i = 0; i < SYNC; i++) begin
            hist_col.push_back(2'd0);
            hist_row.push_back(4'd0);
        end
        m_held = 0; m_streak = 0; m_cand = 0; m_rep = 0;
        e_valid = 0; e_pos = 0;
    endtask

    task automatic model_step();
        logic [1:0] s_col;
        logic [3:0] s_row;
        int nbits, ridx, ccol, crow;
        s_col = hist_col.pop_front();
        s_row = hist_row.pop_front();
        hist_col.push_back(column_index);
        hist_row.push_back(row_in);
        nbits = $countones(s_row);
        ridx = 0;
        for (int i = 0; i < 4; i++) if (s_row[i]) ridx = i;
        ccol = m_cand % 4;
        crow = m_cand / 4;
        e_valid = 0;
        if (!m_held) begin
            if (m_streak == 0) begin
                if (nbits == 1) begin
                    m_cand = ridx*4 + int'(s_col);
                    m_streak = 1;
                end
            end else if (int'(s_col) == ccol) begin
                if (nbits == 1 && ridx == crow) begin
                    m_streak++;
                    if (m_streak == DB) begin
                        m_held = 1; m_streak = 0; m_rep = 0;
                        e_valid = 1; e_pos = m_cand;
                    end
                end else m_streak = 0;
            end
        end else if (int'(s_col) == ccol) begin
            if (!s_row[crow]) begin
                m_streak++;
                m_rep = 0;
                if (m_streak == DB) begin
                    m_held = 0; m_streak = 0;
                end
            end else if (m_streak > 0) begin
                m_streak = 0;
            end else begin
                m_rep++;
`ifdef KEYPAD_REPEAT_EN
                if (m_rep == DELAY || (m_rep > DELAY && (m_rep - DELAY) % RATE == 0)) e_valid = 1;
`endif
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst) model_reset(); else model_step();
            @(negedge clk);
            chk("key_valid", 32'(key_valid), 32'(e_valid));
            chk("key_pos",   32'(key_pos),   32'(e_pos));
            chk("key_value", 32'(key_value), 32'(key_map_ref[e_pos]));
            chk("key_held",  32'(key_held),  32'(m_held));
            if (key_valid === 1'b1) pulses++;
            column_index = column_index + 2'd1;
            row_in = rows_of(keys, column_index);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_pos",   32'(key_pos),   32'd0);
        chk("rst_value", 32'(key_value), 32'd1);
        chk("rst_held",  32'(key_held),  32'd0);
        model_reset();
        cycles(3);
        rst = 1'b0;
    endtask

    initial begin
        int pos, pos2;
        keys = '0;
        column_index = 2'd0;
        row_in = 4'd0;
        do_reset();

        // Idle scanning
        pulses = 0;
        cycles(200);
        chk("idle_pulses", 32'(pulses), 32'd0);

        // Stable press of pos 6, then release
        pulses = 0;
        keys[6] = 1'b1;
        cycles(4*20);
        chk("p6_pulses", 32'(pulses), 32'd1);
        chk("p6_pos",    32'(key_pos), 32'd6);
        chk("p6_value",  32'(key_value), 32'h6);
        chk("p6_held",   32'(key_held), 32'd1);
        keys = '0;
        cycles(4*8);
        chk("p6_released", 32'(key_held), 32'd0);
        chk("p6_pos_kept", 32'(key_pos), 32'd6);

        // Bounce on pos 3: 2 scans, 1 scan gap, then stable
        pulses = 0;
        keys[3] = 1'b1; cycles(8);
        keys = '0;      cycles(4);
        keys[3] = 1'b1; cycles(4*10);
        chk("bounce_pulses", 32'(pulses), 32'd1);
        chk("bounce_value",  32'(key_value), 32'hA);
        keys = '0; cycles(4*8);

        // Two rows in column 1 is multi -> ignored until row 3 drops
        pulses = 0;
        keys[9] = 1'b1; keys[13] = 1'b1;
        cycles(4*10);
        chk("multi_pulses", 32'(pulses), 32'd0);
        keys[13] = 1'b0;
        cycles(4*10);
        chk("multi_drop_pulses", 32'(pulses), 32'd1);
        chk("multi_drop_pos",    32'(key_pos), 32'd9);
        chk("multi_drop_value",  32'(key_value), 32'h8);
        keys = '0; cycles(4*8);

        // First key wins
        pulses = 0;
        keys[13] = 1'b1; cycles(4*10);
        keys[5]  = 1'b1; cycles(4*10);
        chk("first_wins_pulses", 32'(pulses), 32'd1);
        chk("first_wins_value",  32'(key_value), 32'h0);
        keys = '0; cycles(4*10);
        keys[5] = 1'b1; cycles(4*10);
        chk("second_press_pulses", 32'(pulses), 32'd2);
        chk("second_press_value",  32'(key_value), 32'h5);
        keys = '0; cycles(4*8);

        // Reset while held, key re-reported once
        keys[10] = 1'b1; cycles(4*10);
        do_reset();
        pulses = 0;
        cycles(4*10);
        chk("rst_repress_pulses", 32'(pulses), 32'd1);
        chk("rst_repress_pos",    32'(key_pos), 32'd10);
        keys = '0; cycles(4*10);

        // 120-scan hold
        pulses = 0;
        keys[7] = 1'b1; cycles(4*120);
`ifdef KEYPAD_REPEAT_EN
        chk("long_hold_pulses", 32'(pulses), 32'd8);
`else
        chk("long_hold_pulses", 32'(pulses), 32'd1);
`endif
        keys = '0; cycles(4*10);

        // Random presses with bounce and occasional second key
        for (int it = 0; it < 25; it++) begin
            pos = int'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) begin
                keys[pos] = 1'b1; cycles(int'($urandom_range(1, 8)));
                keys = '0;        cycles(int'($urandom_range(1, 6)));
            end
            keys[pos] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                pos2 = int'($urandom_range(0, 15));
                keys[pos2] = 1'b1;
            end
            cycles(4 * int'($urandom_range(4, 40)));
            repeat ($urandom_range(0, 2)) begin
                keys = '0;        cycles(int'($urandom_range(1, 6)));
                keys[pos] = 1'b1; cycles(int'($urandom_range(1, 6)));
            end
            keys = '0;
            cycles(4 * int'($urandom_range(6, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
